conv_ctrl: RTL and testbench
============================

# conv_ctrl

CPU-facing ICB slave register block that sequences the convolution accelerator. Software writes a launch command. The block pulses the accelerator's reset to clear its sticky done flag, fires a single-cycle start, then waits for completion. On completion it records status, counts jobs and cycles, and raises an interrupt. It sits between the SoC peripheral ICB bus and the accelerator's start/done/reset pins.

## Interface
- RST_CYCLES, 2, cycles conv_rst_n is held low before each launch (≥1)
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command ready
- icb_cmd_addr  in  32  byte address; only [3:2] decoded
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_wdata  in  32  write data
- icb_cmd_wmask  in  4  byte enables; only wmask[0] matters
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response ready
- icb_rsp_rdata  out  32  read data (0 for writes)
- conv_rst_n  out  1  accelerator reset, active low
- conv_start  out  1  accelerator start
- conv_done  in  1  accelerator done; sticky until accelerator reset
- irq  out  1  interrupt, level

## Operation
- Register map, by addr[3:2]:
  - 0 CTRL: write bit0=1 launches (self-clearing); bit1 irq_en is RW; reads {30'b0, irq_en, 1'b0}.
  - 1 STATUS: bit0 busy (state≠IDLE); bit1 done_flag, sticky, write-1-to-clear; bit2 pending; other bits read 0.
  - 2 CYCLES: RO, 32-bit, saturating.
  - 3 JOBS: RO, 32-bit, wraps.
- Writes to RO registers are ignored. Any write with wmask[0]=0 is ignored.
- FSM:
  - IDLE: conv_rst_n=1, conv_start=0. A launch goes to RST.
  - RST: conv_rst_n=0 for RST_CYCLES cycles, then FIRE.
  - FIRE: conv_rst_n=1 and conv_start=1 for exactly one cycle. CYCLES clears to 0. Then RUN.
  - RUN: CYCLES increments each cycle, saturating at 0xFFFF_FFFF. When conv_done=1, set done_flag, increment JOBS, and go to RST if pending, else IDLE. Leaving RUN for RST clears pending.
- A launch in any state other than IDLE sets pending; it is one-deep, and extra launches while pending=1 are dropped.
- irq = irq_en & done_flag, registered.

## Timing
- Reset values: state=IDLE, conv_rst_n=0 during reset and 1 in the first cycle after, conv_start=0, irq=0, icb_rsp_valid=0, icb_rsp_rdata=0, all registers 0.
- icb_cmd_ready = rst_n & (~icb_rsp_valid | icb_rsp_ready). At most one transaction is outstanding.
- A command accepted in cycle N produces icb_rsp_valid in cycle N+1. The response holds valid and rdata stable until icb_rsp_ready=1.
- Register writes take effect at the accept edge. A read accepted in the same cycle as an internal update returns the pre-update value.
- Launch accepted in IDLE at cycle N:
  - conv_rst_n=0 in cycles N+1 to N+RST_CYCLES.
  - conv_start=1 in cycle N+RST_CYCLES+1.
  - RUN begins in cycle N+RST_CYCLES+2.
- Completion is sampled in RUN only; conv_done in IDLE, RST or FIRE is ignored. irq rises one cycle after done_flag sets.
- Simultaneous events:
  - A done_flag W1C in the completion cycle: completion wins, and done_flag stays 1.
  - A launch in the completion cycle: it counts as pending, and the FSM goes to RST.
  - Clearing irq_en in the completion cycle: irq stays 0.
- Reset mid-job: the FSM returns to IDLE and all counters and flags clear. conv_rst_n=0 during reset aborts the accelerator.

## Test plan
- Reset, then read all four registers → every read returns 0; irq=0, conv_start=0, conv_rst_n=1 after release.
- Write CTRL=0x3, then assert conv_done 10 cycles after conv_start → conv_rst_n low for exactly 2 cycles, one conv_start pulse, CYCLES=10, JOBS=1, STATUS=0x2, irq=1.
- Write STATUS=0x2 → done_flag clears and irq falls. Then write STATUS=0x2 in the same cycle as a completion → done_flag stays 1.
- Launch three times during RUN → pending=1 and only one extra job runs; JOBS=2 after both complete, with a second reset/start sequence between them.
- Hold icb_rsp_ready=0 for 5 cycles after a read of JOBS → rsp_valid and rdata stay stable, and icb_cmd_ready=0 until the response is taken.
- Assert rst_n=0 mid-RUN with CYCLES=500 → after release, CYCLES=0, busy=0, and a later conv_done=1 is ignored.

Source files
------------

// File: rtl/conv_ctrl.sv
// conv_ctrl: ICB slave register block that sequences the convolution accelerator.
//
// Software writes CTRL.bit0 to launch a job. The block holds the accelerator in
// reset for RST_CYCLES cycles, which clears its sticky done flag. It then pulses
// conv_start for one cycle and counts cycles until conv_done. On completion it
// sets done_flag, bumps JOBS and, if irq_en is set, raises irq one cycle later.
// A launch that arrives while a job is in flight is held as a one-deep pending
// request and starts as soon as the current job completes.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   icb_cmd_*         ICB command channel (valid/ready, addr[3:2] decoded,
//                     read, wdata, wmask[0] gates writes)
//   icb_rsp_*         ICB response channel (valid/ready, rdata)
//   conv_rst_n        accelerator reset, active low
//   conv_start        accelerator start, one-cycle pulse
//   conv_done         accelerator done, sticky until accelerator reset
//   irq               level interrupt = irq_en & done_flag, registered
//
// Handshake: a channel transfers on a cycle where valid and ready are both 1.
// Once the response valid is raised, it and rdata stay stable until rsp_ready
// is 1. A new command is accepted only when no response is left untaken, so at
// most one transaction is outstanding.
//
// Register map (addr[3:2]):
//   0 CTRL    W bit0 launch (self-clearing), RW bit1 irq_en
//   1 STATUS  bit0 busy, bit1 done_flag (W1C), bit2 pending
//   2 CYCLES  RO, cycles spent in RUN for the last job, saturating
//   3 JOBS    RO, completed job count, wrapping
module conv_ctrl #(
    parameter int RST_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic [31:0] icb_cmd_addr,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [3:0]  icb_cmd_wmask,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic [31:0] icb_rsp_rdata,
    output logic        conv_rst_n,
    output logic        conv_start,
    input  logic        conv_done,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_FIRE = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] rst_cnt_q, rst_cnt_d;
    logic          conv_rst_n_q, conv_rst_n_d;
    logic          conv_start_q, conv_start_d;
    logic          irq_en_q, irq_en_d;
    logic          done_flag_q, done_flag_d;
    logic          pending_q, pending_d;
    logic [31:0]   cycles_q, cycles_d;
    logic [31:0]   jobs_q, jobs_d;
    logic          irq_q, irq_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    logic          accept;
    logic          wr_en;
    logic [1:0]    reg_sel;
    logic          launch;
    logic          w1c_done;
    logic          complete;
    logic          relaunch;
    logic [31:0]   rd_mux;

    // Only addr[3:2], wdata[1:0] and wmask[0] carry meaning.
    logic unused_ok;
    assign unused_ok = ^{icb_cmd_addr[31:4], icb_cmd_addr[1:0],
                         icb_cmd_wdata[31:2], icb_cmd_wmask[3:1]};

    assign icb_cmd_ready = rst_n & (~rsp_valid_q | icb_rsp_ready);

    always_comb begin
        accept   = icb_cmd_valid & icb_cmd_ready;
        wr_en    = accept & ~icb_cmd_read & icb_cmd_wmask[0];
        reg_sel  = icb_cmd_addr[3:2];
        launch   = wr_en & (reg_sel == 2'd0) & icb_cmd_wdata[0];
        w1c_done = wr_en & (reg_sel == 2'd1) & icb_cmd_wdata[1];
        complete = (state_q == S_RUN) & conv_done;
        // A launch landing in the completion cycle counts as the pending request.
        relaunch = complete & (pending_q | launch);
    end

    // Reads see the register values before any update made on the same edge.
    always_comb begin
        rd_mux = 32'd0;
        case (reg_sel)
            2'd0: rd_mux = {30'd0, irq_en_q, 1'b0};
            2'd1: rd_mux = {29'd0, pending_q, done_flag_q, (state_q != S_IDLE)};
            2'd2: rd_mux = cycles_q;
            2'd3: rd_mux = jobs_q;
            default: rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        irq_en_d    = irq_en_q;
        done_flag_d = done_flag_q;
        pending_d   = pending_q;
        cycles_d    = cycles_q;
        jobs_d      = jobs_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;

        if (wr_en && (reg_sel == 2'd0)) begin
            irq_en_d = icb_cmd_wdata[1];
        end

        if (launch && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d   = S_RST;
                    rst_cnt_d = '0;
                end
            end
            S_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_FIRE;
                end else begin
                    rst_cnt_d = rst_cnt_q + CW'(1);
                end
            end
            S_FIRE: begin
                state_d  = S_RUN;
                cycles_d = 32'd0;
            end
            S_RUN: begin
                if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
                if (complete) begin
                    jobs_d = jobs_q + 32'd1;
                    if (relaunch) begin
                        state_d   = S_RST;
                        rst_cnt_d = '0;
                        pending_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Completion takes priority over a same-cycle write-1-to-clear.
        if (w1c_done) begin
            done_flag_d = 1'b0;
        end
        if (complete) begin
            done_flag_d = 1'b1;
        end

        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = icb_cmd_read ? rd_mux : 32'd0;
        end else if (icb_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Outputs are registered off the next state so they line up with it.
    always_comb begin
        conv_rst_n_d = (state_d != S_RST);
        conv_start_d = (state_d == S_FIRE);
        irq_d        = irq_en_q & done_flag_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            conv_rst_n_q <= 1'b1;
            conv_start_q <= 1'b0;
            irq_en_q     <= 1'b0;
            done_flag_q  <= 1'b0;
            pending_q    <= 1'b0;
            cycles_q     <= 32'd0;
            jobs_q       <= 32'd0;
            irq_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            conv_rst_n_q <= conv_rst_n_d;
            conv_start_q <= conv_start_d;
            irq_en_q     <= irq_en_d;
            done_flag_q  <= done_flag_d;
            pending_q    <= pending_d;
            cycles_q     <= cycles_d;
            jobs_q       <= jobs_d;
            irq_q        <= irq_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // The accelerator is held in reset for as long as the block itself is.
    assign conv_rst_n    = rst_n & conv_rst_n_q;
    assign conv_start    = conv_start_q;
    assign irq           = irq_q;
    assign icb_rsp_valid = rsp_valid_q;
    assign icb_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl: register access, launch sequencing, W1C versus
// completion, pending launches, response back-pressure and mid-job reset.
module tb_conv_ctrl;

    localparam logic [1:0] R_CTRL   = 2'd0;
    localparam logic [1:0] R_STATUS = 2'd1;
    localparam logic [1:0] R_CYCLES = 2'd2;
    localparam logic [1:0] R_JOBS   = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        icb_cmd_valid = 1'b0;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr = 32'd0;
    logic        icb_cmd_read = 1'b0;
    logic [31:0] icb_cmd_wdata = 32'd0;
    logic [3:0]  icb_cmd_wmask = 4'd0;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready = 1'b1;
    logic [31:0] icb_rsp_rdata;
    logic        conv_rst_n;
    logic        conv_start;
    logic        conv_done = 1'b0;
    logic        irq;

    conv_ctrl #(.RST_CYCLES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .conv_rst_n    (conv_rst_n),
        .conv_start    (conv_start),
        .conv_done     (conv_done),
        .irq           (irq)
    );

    // Cycle counter and accelerator-pin monitor, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rst_low_cnt = 0;
    int start_cnt   = 0;
    int start_cyc   = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!conv_rst_n) rst_low_cnt <= rst_low_cnt + 1;
            if (conv_start) begin
                start_cnt <= start_cnt + 1;
                start_cyc <= cyc;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    int acc_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_xfer(input logic rd, input logic [1:0] idx, input logic [31:0] wd,
                            input logic [3:0] msk, output logic [31:0] rdata);
        int t;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = {28'd0, idx, 2'b00};
        icb_cmd_wdata = wd;
        icb_cmd_wmask = msk;
        icb_rsp_ready = 1'b1;
        t = 0;
        while (!icb_cmd_ready && t < 50) begin
            tick(1);
            t++;
        end
        if (t >= 50) check("cmd_ready_timeout", 32'(icb_cmd_ready), 32'd1);
        tick(1);
        acc_cyc       = cyc;
        icb_cmd_valid = 1'b0;
        check("rsp_valid", 32'(icb_rsp_valid), 32'd1);
        rdata = icb_rsp_rdata;
        tick(1);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [31:0] wd);
        logic [31:0] dummy;
        bus_xfer(1'b0, idx, wd, 4'hF, dummy);
    endtask

    task automatic expect_rd(input string tag, input logic [1:0] idx, input logic [31:0] exp);
        logic [31:0] r;
        exp_q.push_back(exp);
        bus_xfer(1'b1, idx, 32'd0, 4'hF, r);
        check(tag, r, exp_q.pop_front());
    endtask

    task automatic wait_start();
        int t;
        t = 0;
        while (!conv_start && t < 20) begin
            tick(1);
            t++;
        end
        check("start_seen", 32'(conv_start), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base_low;
        int base_start;
        logic [31:0] dummy;

        // Reset state
        tick(3);
        check("rst_conv_rst_n", 32'(conv_rst_n), 32'd0);
        check("rst_conv_start", 32'(conv_start), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(icb_cmd_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_conv_rst_n", 32'(conv_rst_n), 32'd1);
        check("rel_rsp_rdata", icb_rsp_rdata, 32'd0);
        expect_rd("rd_ctrl0", R_CTRL, 32'd0);
        expect_rd("rd_status0", R_STATUS, 32'd0);
        expect_rd("rd_cycles0", R_CYCLES, 32'd0);
        expect_rd("rd_jobs0", R_JOBS, 32'd0);

        // Ignored writes: wmask[0]=0, and writes to RO registers
        base_low = rst_low_cnt;
        bus_xfer(1'b0, R_CTRL, 32'h3, 4'hE, dummy);
        tick(4);
        check("nomask_no_launch", 32'(rst_low_cnt - base_low), 32'd0);
        expect_rd("nomask_ctrl", R_CTRL, 32'd0);
        expect_rd("nomask_status", R_STATUS, 32'd0);
        wr(R_CYCLES, 32'h0000_FFFF);
        wr(R_JOBS, 32'h1);
        expect_rd("ro_cycles", R_CYCLES, 32'd0);
        expect_rd("ro_jobs", R_JOBS, 32'd0);

        // Basic job: done 10 cycles after start
        base_low   = rst_low_cnt;
        base_start = start_cnt;
        wr(R_CTRL, 32'h3);
        wait_start();
        tick(10);
        conv_done = 1'b1;
        tick(1);
        conv_done = 1'b0;
        tick(1);
        check("job1_irq", 32'(irq), 32'd1);
        check("job1_rst_low", 32'(rst_low_cnt - base_low), 32'd2);
        check("job1_starts", 32'(start_cnt - base_start), 32'd1);
        check("job1_start_lat", 32'(start_cyc - acc_cyc), 32'd2);
        expect_rd("job1_cycles", R_CYCLES, 32'd10);
        expect_rd("job1_jobs", R_JOBS, 32'd1);
        expect_rd("job1_status", R_STATUS, 32'h2);
        expect_rd("job1_ctrl", R_CTRL, 32'h2);

        // W1C done_flag, then W1C in the completion cycle
        wr(R_STATUS, 32'h2);
        tick(1);
        check("w1c_irq", 32'(irq), 32'd0);
        expect_rd("w1c_status", R_STATUS, 32'd0);
        wr(R_CTRL, 32'h3);
        wait_start();
        tick(5);
        conv_done     = 1'b1;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = {28'd0, R_STATUS, 2'b00};
        icb_cmd_wdata = 32'h2;
        icb_cmd_wmask = 4'hF;
        icb_rsp_ready = 1'b1;
        check("race_cmd_ready", 32'(icb_cmd_ready), 32'd1);
        tick(1);
        icb_cmd_valid = 1'b0;
        conv_done     = 1'b0;
        check("race_rsp_valid", 32'(icb_rsp_valid), 32'd1);
        tick(1);
        expect_rd("race_status", R_STATUS, 32'h2);
        expect_rd("race_cycles", R_CYCLES, 32'd5);
        expect_rd("race_jobs", R_JOBS, 32'd2);
        check("race_irq", 32'(irq), 32'd1);

        // Three launches during RUN: one pending, one extra job
        wr(R_STATUS, 32'h2);
        base_low   = rst_low_cnt;
        base_start = start_cnt;
        wr(R_CTRL, 32'h3);
        wait_start();
        tick(1);
        wr(R_CTRL, 32'h3);
        wr(R_CTRL, 32'h3);
        wr(R_CTRL, 32'h3);
        expect_rd("pend_status", R_STATUS, 32'h5);
        tick(2);
        conv_done = 1'b1;
        tick(1);
        conv_done = 1'b0;
        wait_start();
        tick(1);
        expect_rd("pend_status2", R_STATUS, 32'h3);
        tick(4);
        conv_done = 1'b1;
        tick(1);
        conv_done = 1'b0;
        tick(10);
        check("pend_starts", 32'(start_cnt - base_start), 32'd2);
        check("pend_rst_low", 32'(rst_low_cnt - base_low), 32'd4);
        // two earlier jobs plus the launched one and its pending follow-up
        expect_rd("pend_jobs", R_JOBS, 32'd4);
        expect_rd("pend_status3", R_STATUS, 32'h2);

        // Response back-pressure on a JOBS read
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = {28'd0, R_JOBS, 2'b00};
        icb_cmd_wmask = 4'hF;
        icb_rsp_ready = 1'b0;
        check("bp_ready_idle", 32'(icb_cmd_ready), 32'd1);
        tick(1);
        icb_cmd_addr = {28'd0, R_CYCLES, 2'b00};
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(icb_rsp_valid), 32'd1);
            check("bp_rsp_rdata", icb_rsp_rdata, 32'd4);
            check("bp_cmd_ready", 32'(icb_cmd_ready), 32'd0);
            tick(1);
        end
        icb_rsp_ready = 1'b1;
        #1;
        check("bp_ready_release", 32'(icb_cmd_ready), 32'd1);
        tick(1);
        icb_cmd_valid = 1'b0;
        check("bp_next_valid", 32'(icb_rsp_valid), 32'd1);
        check("bp_next_rdata", icb_rsp_rdata, 32'd7);
        tick(1);
        check("bp_drained", 32'(icb_rsp_valid), 32'd0);

        // Reset in the middle of RUN
        wr(R_CTRL, 32'h3);
        wait_start();
        tick(501);
        expect_rd("mid_cycles", R_CYCLES, 32'd500);
        rst_n = 1'b0;
        tick(2);
        check("mid_rst_conv_rst_n", 32'(conv_rst_n), 32'd0);
        rst_n = 1'b1;
        #1;
        check("mid_rel_conv_rst_n", 32'(conv_rst_n), 32'd1);
        expect_rd("mid_cycles0", R_CYCLES, 32'd0);
        expect_rd("mid_status0", R_STATUS, 32'd0);
        expect_rd("mid_jobs0", R_JOBS, 32'd0);
        expect_rd("mid_ctrl0", R_CTRL, 32'd0);
        conv_done = 1'b1;
        tick(5);
        conv_done = 1'b0;
        expect_rd("idle_done_jobs", R_JOBS, 32'd0);
        expect_rd("idle_done_status", R_STATUS, 32'd0);
        check("idle_done_irq", 32'(irq), 32'd0);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
